mdu_issue_ctrl: RTL
===================

// Module: mdu_issue_ctrl
// PURPOSE
//  Sequencer and hazard controller for the pipelined CPU's multiply/divide unit (MDU).
//  - Decodes the E-stage instruction's MDU op and issues start / HI-LO-write commands to the MDU.
//  - Mirrors the MDU latency with its own state machine and counter.
//  - Stalls the D stage while an MDU-dependent instruction would observe a busy HI/LO.
//  - Suppresses issue on an exception/interrupt request (req).
// PARAMETERS
//  MUL_LAT  5   cycles from start to HI/LO valid for mult/multu (>=2)
//  DIV_LAT  10  cycles from start to HI/LO valid for div/divu (>=2)
//  CNT_W    16  width of the saturating op counters
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous reset, active-high
//  req        in   1      exception/interrupt flush of E stage this cycle
//  e_valid    in   1      E-stage instruction valid (not a bubble)
//  e_op       in   4      E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//  d_is_mdu   in   1      D-stage instruction is any op 1..8
//  mdu_start  out  1      combinational: start pulse to MDU
//  mdu_op     out  4      combinational: e_op when a command is issued, else 0
//  hilo_we    out  1      combinational: mthi/mtlo write command to MDU
//  busy       out  1      registered: MDU operation in flight
//  stall_d    out  1      combinational: freeze PC/F/D, bubble into E
//  done       out  1      registered: 1-cycle pulse when HI/LO take the result
//  mul_count  out  CNT_W  completed mult/multu operations, saturating
//  div_count  out  CNT_W  completed div/divu operations, saturating
//  err        out  1      sticky: illegal issue while busy
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, cnt=0, busy=0, done=0, mul_count=0, div_count=0, err=0.
//   - Reset overrides everything, including mid-operation; the op is dropped and no done pulse occurs.
//  Issue conditions:
//   - issue  = e_valid & !req & !reset & state==IDLE.
//   - mdu_start = issue & e_op in {1..4}.
//   - hilo_we  = issue & e_op in {7,8}.
//   - mdu_op   = e_op when mdu_start|hilo_we|(e_valid & e_op in {5,6}), else 0.
//  State machine (states IDLE, MUL, DIV, DONE):
//   - IDLE -> MUL on mdu_start with op 1/2: cnt<=MUL_LAT-1, busy<=1.
//   - IDLE -> DIV on mdu_start with op 3/4: cnt<=DIV_LAT-1, busy<=1.
//   - MUL/DIV: cnt decrements each cycle.
//   - MUL/DIV at cnt==1 -> DONE: busy<=0, done<=1, and the matching counter increments (holds at all-ones).
//   - DONE -> IDLE unconditionally next cycle; done<=0. DONE accepts a new issue exactly like IDLE.
//   - Result: busy high for exactly LAT-1 cycles after the start edge; done asserts LAT cycles after mdu_start is sampled.
//  req handling:
//   - req in the issue cycle blocks start/hilo_we; state is unchanged.
//   - req while MUL/DIV is in flight does not cancel the op (already committed); it completes normally.
//  Stall:
//   - stall_d = d_is_mdu & (busy | mdu_start).
//   - The stall covers the start cycle and every busy cycle; it releases in the DONE cycle.
//  Illegal issue:
//   - e_valid & e_op in {1..4,7,8} while busy (only possible if the stall is bypassed) issues nothing, keeps state, and sets err.
//   - err clears only on reset.
//  Simultaneous events:
//   - reset beats req, and req beats issue.
//   - A completion and a counter saturation in the same cycle leave the counter at max.
// TESTING
//  1 mult, e_valid=1, e_op=1, no req -> mdu_start=1 for 1 cycle; busy=1 for 4 cycles; done pulse at cycle 5; mul_count=1.
//  2 div issued, with d_is_mdu=1 held throughout -> stall_d=1 from the start cycle through 9 busy cycles; stall_d=0 in the DONE cycle; div_count=1.
//  3 divu issued with req=1 in the same cycle -> mdu_start=0, busy stays 0, no done; div_count=0.
//  4 mult in flight, req=1 at cycle 2 -> op still completes at cycle 5 with done=1.
//  5 div in flight, reset=1 at cycle 4 -> next edge: busy=0, state IDLE, counters 0, no done pulse.
//  6 mthi forced while busy -> hilo_we=0 and err=1 (sticky); back-to-back mult issued in the DONE cycle -> accepted, busy=1 next cycle.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// Issue sequencer and D-stage hazard control for the multiply/divide unit.
// Tracks MDU latency locally so busy/done/stall line up with HI/LO becoming valid.
module mdu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic             d_is_mdu,
    output logic             mdu_start,
    output logic [3:0]       mdu_op,
    output logic             hilo_we,
    output logic             busy,
    output logic             stall_d,
    output logic             done,
    output logic [CNT_W-1:0] mul_count,
    output logic [CNT_W-1:0] div_count,
    output logic             err
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned LAT_W   = $clog2(MAX_LAT);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   mul_count_q, mul_count_d;
    logic [CNT_W-1:0]   div_count_q, div_count_d;
    logic               err_q, err_d;

    logic is_start_op, is_wr_op, is_mf_op, is_mul_op;
    logic can_issue, issue;

    always_comb begin
        is_start_op = (e_op >= 4'd1) && (e_op <= 4'd4);
        is_mul_op   = (e_op == 4'd1) || (e_op == 4'd2);
        is_mf_op    = (e_op == 4'd5) || (e_op == 4'd6);
        is_wr_op    = (e_op == 4'd7) || (e_op == 4'd8);
        // DONE behaves like IDLE for acceptance so back-to-back ops lose no cycle
        can_issue   = (state_q == StIdle) || (state_q == StDone);
        issue       = e_valid && !req && !reset && can_issue;
        mdu_start   = issue && is_start_op;
        hilo_we     = issue && is_wr_op;
        mdu_op      = (mdu_start || hilo_we || (e_valid && is_mf_op)) ? e_op : 4'd0;
        stall_d     = d_is_mdu && (busy_q || mdu_start);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mul_count_d = mul_count_q;
        div_count_d = div_count_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (mdu_start) begin
                    busy_d = 1'b1;
                    if (is_mul_op) begin
                        state_d = StMul;
                        cnt_d   = LAT_W'(MUL_LAT - 1);
                    end else begin
                        state_d = StDiv;
                        cnt_d   = LAT_W'(DIV_LAT - 1);
                    end
                end
            end
            StMul, StDiv: begin
                if (cnt_q == LAT_W'(1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (state_q == StMul) begin
                        if (mul_count_q != '1) mul_count_d = mul_count_q + CNT_W'(1);
                    end else begin
                        if (div_count_q != '1) div_count_d = div_count_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Only reachable when something upstream ignored stall_d
        if (e_valid && (is_start_op || is_wr_op) && busy_q) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mul_count_q <= '0;
            div_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mul_count_q <= mul_count_d;
            div_count_q <= div_count_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mul_count = mul_count_q;
    assign div_count = div_count_q;
    assign err       = err_q;

endmodule
